lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Multi-cycle load/store unit for the next-generation RV32I core. It replaces the single-cycle combinational data-memory path with a request/acknowledge handshake toward data memory. It handles byte, halfword and word loads and stores, including sign and zero extension and byte-lane steering. Misaligned accesses are either split into two aligned accesses or rejected, selected by parameter, and a wait-state timeout flags an error.

## Interface
- `MISALIGN_SPLIT`, 1: 1 = split misaligned accesses into two aligned words; 0 = reject them with `rsp_err`.
- `TIMEOUT`, 15: maximum cycles `mem_req` may stay high without `mem_ack` before the access aborts. Range 1..255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle and able to accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3.
  - Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
  - Stores: 0 SB, 1 SH, 2 SW.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `rsp_valid` out 1: one-cycle completion pulse, for both loads and stores.
- `rsp_rdata` out 32: extended load result; 0 for stores and errors.
- `rsp_err` out 1: qualifies `rsp_valid`. Set for misaligned-with-split-disabled, illegal funct3, or timeout.
- `mem_req` out 1: memory access active.
- `daddr` out 32: word-aligned address; bits [1:0] are always 0.
- `dwdata` out 32: lane-steered store data.
- `we` out 4: byte write enables. Nonzero only while `mem_req`=1 and the access is a store.
- `mem_ack` in 1: memory done this cycle. For loads, `drdata` is valid in the same cycle.
- `drdata` in 32: read word.

## Operation
- **States:** IDLE, ACC1, ACC2, RESP.
- **Reset:** while `reset`=0 the state is IDLE.
  - Outputs during reset: `req_ready`=0, `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0, `mem_req`=0, `daddr`=0, `dwdata`=0, `we`=0, and the timeout counter is 0.
  - After release, `req_ready`=1 whenever the state is IDLE.
- **IDLE:**
  - A request is accepted when `req_valid`&`req_ready`. The unit latches `req_addr`, `req_wdata`, `req_we` and `req_funct3`, and computes `off=addr[1:0]` and `size` (1, 2 or 4 bytes).
  - Illegal funct3 (load 3/6/7, store ≥3) goes to RESP with error and makes no memory access.
  - An access is misaligned when `off+size>4`. With `MISALIGN_SPLIT`=0 a misaligned access goes to RESP with error and no memory access; otherwise it goes to ACC1.
- **Lane steering:**
  - `mask = (1<<size)-1`. `bem = mask<<off`, 8 bits wide.
  - `dwdata = rotl(wdata, 8*off)` for both halves.
  - ACC1: `daddr = addr & ~3`, `we = bem[3:0]`.
  - ACC2: `daddr = (addr & ~3) + 4`, wrapping modulo 2^32; `we = bem[7:4]`.
  - Loads drive `we = 0`.
- **ACC1 and ACC2:**
  - `mem_req`=1, with `daddr`, `dwdata` and `we` held stable until `mem_ack`.
  - On `mem_ack` the unit captures `drdata` as D0 (ACC1) or D1 (ACC2). ACC1 then goes to ACC2 if split, otherwise to RESP; ACC2 goes to RESP.
- **Load result:**
  - `raw = ({D1,D0} >> 8*off)[31:0]`. D1 is 0 when the access is not split.
  - The result is truncated to `size`, then sign-extended (LB, LH) or zero-extended (LBU, LHU). LW passes through.
- **Timeout:**
  - The counter clears on entering each ACC state and increments each ACC cycle without `mem_ack`.
  - When `mem_ack` is still absent after `TIMEOUT` cycles, the unit goes to RESP with `rsp_err`=1 and `rsp_rdata`=0.
  - If ACC1 of a split store already completed, its write is not undone.
- **RESP:**
  - `rsp_valid`=1 for exactly one cycle; the unit then returns to IDLE.
  - There is no response back-pressure.
- **Ignored inputs:** `mem_ack` is ignored outside ACC1/ACC2. `req_valid` is ignored outside IDLE; the requester holds it.
- **Reset mid-access:** the unit returns immediately (asynchronously) to IDLE with `mem_req`=0. No response is produced for the aborted request.

## Timing
- Request acceptance is cycle 0; ACC1 starts in cycle 1.
- Aligned access with zero-wait memory (`mem_ack` in the first ACC1 cycle): `rsp_valid` in cycle 2, i.e. two-cycle latency.
- Each wait state adds one cycle. A split access adds the ACC2 cycles.
- Error without memory access: `rsp_valid` in cycle 1.
- Timeout: `rsp_valid` is asserted in the cycle after the `TIMEOUT`-th ACC cycle without `mem_ack`.
- Throughput: back-to-back requests; the next acceptance is possible in the cycle after RESP.
- The response outputs (`rsp_valid`, `rsp_err`, `rsp_rdata`) are registered. The memory-side outputs are driven directly from the state register and latched request.

## Test plan
- **Reset values:** assert `reset`=0 mid-ACC1 with `mem_req`=1 → `mem_req` drops without waiting for a clock edge, and all outputs reset to the values listed in Operation; after release `req_ready`=1.
- **Aligned LW, zero wait:**
  - Stimulus: LW at 0x100, `mem_ack` in the first ACC1 cycle, `drdata`=0xDEADBEEF.
  - Expected: `daddr`=0x100, `we`=0. `rsp_valid` in cycle 2 with `rsp_rdata`=0xDEADBEEF and `rsp_err`=0.
- **Sub-word loads and store:**
  - LB at 0x103 with `drdata`=0x80112233 → `rsp_rdata`=0xFFFFFF80.
  - LBU at the same address → `rsp_rdata`=0x00000080.
  - SH of 0x0000ABCD at 0x202 → `daddr`=0x200, `we`=0b1100, `dwdata`=0xABCDxxxx.
- **Split SW:**
  - Stimulus: `MISALIGN_SPLIT`=1, SW of 0x11223344 at 0x1FD.
  - Expected ACC1: `daddr`=0x1FC, `we`=0b1110, `dwdata`=0x22334411.
  - Expected ACC2: `daddr`=0x200, `we`=0b0001.
  - A split LW at 0x1FD with D0=0xAABBCCDD and D1=0x11223344 → `rsp_rdata`=0x44AABBCC.
- **Misaligned reject:** `MISALIGN_SPLIT`=0, LH at 0x003 → `rsp_valid` with `rsp_err`=1 in cycle 1, and `mem_req` never asserted.
- **Timeout:** `TIMEOUT`=4 and `mem_ack` held at 0 → `mem_req` high for 4 cycles, then a `rsp_valid`/`rsp_err` pulse with `rsp_rdata`=0, then `req_ready`=1.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Multi-cycle RV32I load/store unit with a req/ack data-memory handshake.
// Handles sub-word lane steering, sign/zero extension, split misaligned
// accesses and a wait-state timeout.
module lsu_ctrl #(
    parameter bit          MISALIGN_SPLIT = 1'b1,
    parameter int unsigned TIMEOUT        = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req,
    output logic [31:0] daddr,
    output logic [31:0] dwdata,
    output logic [3:0]  we,
    input  logic        mem_ack,
    input  logic [31:0] drdata
);

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_e;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_e      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] d0_q;
    logic [31:0] rsp_rdata_q;
    logic [2:0]  f3_q;
    logic [7:0]  cnt_q;
    logic        we_q;
    logic        split_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;

    logic [2:0]  in_size;
    logic        in_illegal;
    logic        in_mis;
    logic [1:0]  off_q;
    logic [3:0]  mask;
    logic [7:0]  bem;
    logic [31:0] rot;
    logic        acc;

    function automatic logic [31:0] load_ext(input logic [63:0] pair,
                                             input logic [1:0]  off,
                                             input logic [2:0]  f3);
        logic [31:0] raw;
        raw = 32'(pair >> {off, 3'b000});
        unique case (f3)
            3'd0:    load_ext = {{24{raw[7]}}, raw[7:0]};
            3'd1:    load_ext = {{16{raw[15]}}, raw[15:0]};
            3'd4:    load_ext = {24'd0, raw[7:0]};
            3'd5:    load_ext = {16'd0, raw[15:0]};
            default: load_ext = raw;
        endcase
    endfunction

    // Decode of the incoming request, used only at acceptance.
    always_comb begin
        unique case (req_funct3[1:0])
            2'd0:    in_size = 3'd1;
            2'd1:    in_size = 3'd2;
            default: in_size = 3'd4;
        endcase
        if (req_we) begin
            in_illegal = req_funct3 > 3'd2;
        end else begin
            in_illegal = (req_funct3[1:0] == 2'b11) || (req_funct3[2:1] == 2'b11);
        end
        in_mis = ({1'b0, req_addr[1:0]} + in_size) > 3'd4;
    end

    // Lane steering from the latched request.
    always_comb begin
        off_q = addr_q[1:0];
        unique case (f3_q[1:0])
            2'd0:    mask = 4'b0001;
            2'd1:    mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
        bem = 8'({4'b0000, mask} << off_q);
        rot = 32'({wdata_q, wdata_q} >> (6'd32 - {1'b0, off_q, 3'b000}));
        acc = (state_q == ACC1) || (state_q == ACC2);
    end

    assign req_ready = reset && (state_q == IDLE);
    assign mem_req   = acc;
    assign dwdata    = acc ? rot : 32'd0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

    always_comb begin
        daddr = 32'd0;
        we    = 4'd0;
        if (state_q == ACC1) begin
            daddr = {addr_q[31:2], 2'b00};
            we    = we_q ? bem[3:0] : 4'd0;
        end else if (state_q == ACC2) begin
            daddr = {addr_q[31:2] + 30'd1, 2'b00};
            we    = we_q ? bem[7:4] : 4'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            d0_q        <= '0;
            f3_q        <= '0;
            we_q        <= 1'b0;
            split_q     <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        split_q <= in_mis;
                        cnt_q   <= '0;
                        if (in_illegal || (in_mis && (MISALIGN_SPLIT == 1'b0))) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else begin
                            state_q <= ACC1;
                        end
                    end
                end
                ACC1: begin
                    if (mem_ack) begin
                        d0_q  <= drdata;
                        cnt_q <= '0;
                        if (split_q) begin
                            state_q <= ACC2;
                        end else begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            rsp_rdata_q <= we_q ? 32'd0
                                         : load_ext({32'd0, drdata}, off_q, f3_q);
                        end
                    end else if (cnt_q == TO_LAST) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ACC2: begin
                    if (mem_ack) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= we_q ? 32'd0
                                     : load_ext({drdata, d0_q}, off_q, f3_q);
                    end else if (cnt_q == TO_LAST) begin
                        // A completed first half of a split store stays written.
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: one split-enabled instance with a short
// timeout and one reject-misaligned instance sharing the request bus.
module tb_lsu_ctrl;

    logic        clk;
    logic        reset;
    logic        rv_s;
    logic        rv_r;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_ack;
    logic [31:0] drdata;

    logic        s_ready, s_rvalid, s_err, s_mreq;
    logic [31:0] s_rdata, s_daddr, s_dwdata;
    logic [3:0]  s_we;
    logic        r_ready, r_rvalid, r_err, r_mreq;
    logic [31:0] r_rdata, r_daddr, r_dwdata;
    logic [3:0]  r_we;

    int n_pass  = 0;
    int n_total = 0;

    lsu_ctrl #(.MISALIGN_SPLIT(1'b1), .TIMEOUT(4)) u_split (
        .clk(clk), .reset(reset),
        .req_valid(rv_s), .req_ready(s_ready),
        .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(s_rvalid), .rsp_rdata(s_rdata), .rsp_err(s_err),
        .mem_req(s_mreq), .daddr(s_daddr), .dwdata(s_dwdata), .we(s_we),
        .mem_ack(mem_ack), .drdata(drdata)
    );

    lsu_ctrl #(.MISALIGN_SPLIT(1'b0), .TIMEOUT(15)) u_rej (
        .clk(clk), .reset(reset),
        .req_valid(rv_r), .req_ready(r_ready),
        .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(r_rvalid), .rsp_rdata(r_rdata), .rsp_err(r_err),
        .mem_req(r_mreq), .daddr(r_daddr), .dwdata(r_dwdata), .we(r_we),
        .mem_ack(mem_ack), .drdata(drdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        req_we     = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
        rv_s       = 1'b1;
        cyc();
        rv_s       = 1'b0;
    endtask

    task automatic ack(input logic [31:0] d);
        mem_ack = 1'b1;
        drdata  = d;
        cyc();
        mem_ack = 1'b0;
        drdata  = 32'd0;
    endtask

    initial begin
        reset = 1'b0; rv_s = 1'b0; rv_r = 1'b0;
        req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        mem_ack = 1'b0; drdata = 32'd0;
        cyc(); cyc();
        chk("rst_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_mreq", {31'd0, s_mreq}, 32'd0);
        chk("rst_rvalid", {31'd0, s_rvalid}, 32'd0);
        reset = 1'b1;
        #1;
        chk("rel_ready", {31'd0, s_ready}, 32'd1);

        // Aligned LW, zero wait
        issue(1'b0, 3'd2, 32'h100, 32'd0);
        chk("lw_mreq", {31'd0, s_mreq}, 32'd1);
        chk("lw_daddr", s_daddr, 32'h100);
        chk("lw_we", {28'd0, s_we}, 32'd0);
        chk("lw_ready_busy", {31'd0, s_ready}, 32'd0);
        ack(32'hDEADBEEF);
        chk("lw_rvalid", {31'd0, s_rvalid}, 32'd1);
        chk("lw_rdata", s_rdata, 32'hDEADBEEF);
        chk("lw_err", {31'd0, s_err}, 32'd0);
        cyc();
        chk("lw_rvalid_off", {31'd0, s_rvalid}, 32'd0);
        chk("lw_ready_back", {31'd0, s_ready}, 32'd1);

        // LB / LBU at 0x103
        issue(1'b0, 3'd0, 32'h103, 32'd0);
        chk("lb_daddr", s_daddr, 32'h100);
        ack(32'h80112233);
        chk("lb_rdata", s_rdata, 32'hFFFFFF80);
        cyc();
        issue(1'b0, 3'd4, 32'h103, 32'd0);
        ack(32'h80112233);
        chk("lbu_rdata", s_rdata, 32'h00000080);
        cyc();

        // SH of 0xABCD at 0x202
        issue(1'b1, 3'd1, 32'h202, 32'h0000ABCD);
        chk("sh_daddr", s_daddr, 32'h200);
        chk("sh_we", {28'd0, s_we}, 32'hC);
        chk("sh_dwdata_hi", {16'd0, s_dwdata[31:16]}, 32'hABCD);
        ack(32'h55555555);
        chk("sh_rvalid", {31'd0, s_rvalid}, 32'd1);
        chk("sh_rdata", s_rdata, 32'd0);
        cyc();

        // Split SW at 0x1FD
        issue(1'b1, 3'd2, 32'h1FD, 32'h11223344);
        chk("ssw1_daddr", s_daddr, 32'h1FC);
        chk("ssw1_we", {28'd0, s_we}, 32'hE);
        chk("ssw1_dwdata", s_dwdata, 32'h22334411);
        ack(32'd0);
        chk("ssw2_mreq", {31'd0, s_mreq}, 32'd1);
        chk("ssw2_daddr", s_daddr, 32'h200);
        chk("ssw2_we", {28'd0, s_we}, 32'h1);
        ack(32'd0);
        chk("ssw_rvalid", {31'd0, s_rvalid}, 32'd1);
        chk("ssw_err", {31'd0, s_err}, 32'd0);
        cyc();

        // Split LW at 0x1FD
        issue(1'b0, 3'd2, 32'h1FD, 32'd0);
        chk("slw1_we", {28'd0, s_we}, 32'd0);
        ack(32'hAABBCCDD);
        chk("slw2_we", {28'd0, s_we}, 32'd0);
        ack(32'h11223344);
        chk("slw_rdata", s_rdata, 32'h44AABBCC);
        cyc();

        // LH with two wait states
        issue(1'b0, 3'd1, 32'h102, 32'd0);
        cyc();
        chk("wait_mreq", {31'd0, s_mreq}, 32'd1);
        cyc();
        chk("wait_daddr", s_daddr, 32'h100);
        chk("wait_rvalid", {31'd0, s_rvalid}, 32'd0);
        ack(32'h80015555);
        chk("wait_rdata", s_rdata, 32'hFFFF8001);
        cyc();

        // Split LH wrapping past the top of the address space
        issue(1'b0, 3'd1, 32'hFFFFFFFF, 32'd0);
        chk("wrap1_daddr", s_daddr, 32'hFFFFFFFC);
        ack(32'h12000000);
        chk("wrap2_daddr", s_daddr, 32'h00000000);
        ack(32'h00000034);
        chk("wrap_rdata", s_rdata, 32'h00003412);
        cyc();

        // Illegal funct3
        issue(1'b0, 3'd3, 32'h0, 32'd0);
        chk("ill_rvalid", {31'd0, s_rvalid}, 32'd1);
        chk("ill_err", {31'd0, s_err}, 32'd1);
        chk("ill_mreq", {31'd0, s_mreq}, 32'd0);
        cyc();

        // Timeout (TIMEOUT=4)
        issue(1'b0, 3'd2, 32'h300, 32'd0);
        chk("to_mreq1", {31'd0, s_mreq}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("to_mreq", {31'd0, s_mreq}, 32'd1);
        end
        cyc();
        chk("to_rvalid", {31'd0, s_rvalid}, 32'd1);
        chk("to_err", {31'd0, s_err}, 32'd1);
        chk("to_rdata", s_rdata, 32'd0);
        chk("to_mreq_off", {31'd0, s_mreq}, 32'd0);
        cyc();
        chk("to_ready", {31'd0, s_ready}, 32'd1);

        // Misaligned reject on the non-split instance
        req_we = 1'b0; req_funct3 = 3'd1; req_addr = 32'h3;
        rv_r = 1'b1;
        #1;
        chk("rej_mreq0", {31'd0, r_mreq}, 32'd0);
        cyc();
        rv_r = 1'b0;
        chk("rej_rvalid", {31'd0, r_rvalid}, 32'd1);
        chk("rej_err", {31'd0, r_err}, 32'd1);
        chk("rej_mreq1", {31'd0, r_mreq}, 32'd0);
        cyc();
        chk("rej_ready", {31'd0, r_ready}, 32'd1);

        // Reset in the middle of a store access
        issue(1'b1, 3'd2, 32'h400, 32'hCAFEF00D);
        chk("mid_we", {28'd0, s_we}, 32'hF);
        chk("mid_mreq", {31'd0, s_mreq}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_mreq_drop", {31'd0, s_mreq}, 32'd0);
        chk("mid_daddr", s_daddr, 32'd0);
        chk("mid_dwdata", s_dwdata, 32'd0);
        chk("mid_we0", {28'd0, s_we}, 32'd0);
        chk("mid_ready", {31'd0, s_ready}, 32'd0);
        chk("mid_rdata", s_rdata, 32'd0);
        cyc();
        reset = 1'b1;
        #1;
        chk("mid_ready_rel", {31'd0, s_ready}, 32'd1);
        cyc();
        chk("mid_no_rsp", {31'd0, s_rvalid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
